cpu_boot_loader: RTL and testbench

// - Upstream of CPU_single_cycle: streams a program into instruction memory, then releases CPU reset.
// - Accepts 32-bit words over a valid/ready stream and writes them to consecutive imem addresses from 0.
// - Holds the CPU in reset for a programmable delay after the last word, then sets cpu_rst_n=1.
// - Replaces the fixed-time reset release used in bench-only bring-up.

---
 rtl/cpu_boot_loader.sv | 165 ++++++++++++++++
 tb/tb_cpu_boot_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_loader.sv
// Streams a program into instruction memory from word address 0, then holds the CPU
// in reset for BOOT_DELAY cycles before releasing it. Optional macro: BOOT_CHECKSUM_EN.
module cpu_boot_loader #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BOOT_DELAY = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst_n,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned HOLD_W = $clog2(BOOT_DELAY) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rst_n_q, rst_n_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              accept;
  logic              full;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    code_d  = code_q;
    accept  = in_valid & ready_q;
    full    = (count_q == CNT_W'(DEPTH));
`ifdef BOOT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
`ifdef BOOT_CHECKSUM_EN
          // Final word is a checksum over the load; it is compared, never written
          if (in_last) begin
            if (in_data == sum_q) begin
              state_d = S_HOLD;
              hold_d  = '0;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
              code_d  = ERR_CSUM;
            end
          end else
`endif
          if (full) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = ERR_OVF;
          end else begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = in_data;
            count_d = count_q + CNT_W'(1);
            hold_d  = '0;
            state_d = in_last ? S_HOLD : S_LOAD;
`ifdef BOOT_CHECKSUM_EN
            sum_d   = sum_q + in_data;
`endif
          end
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(BOOT_DELAY - 1)) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (restart) begin
          state_d = S_IDLE;
          count_d = '0;
`ifdef BOOT_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    rst_n_d = (state_d == S_RUN);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hold_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rst_n_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rst_n_q <= rst_n_d;
      err_q   <= err_d;
      code_q  <= code_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_n  = rst_n_q;
  assign word_count = count_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed bench for cpu_boot_loader: load, flow control, overflow, restart, async reset
// and (with BOOT_CHECKSUM_EN) checksum acceptance/rejection.
module tb_cpu_boot_loader;

  logic        CLK;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        restart;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic [6:0]  word_count;
  logic        err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  cpu_boot_loader dut (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
    .word_count(word_count), .err(err), .err_code(err_code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write monitor: log every imem write seen mid-cycle
  always @(negedge CLK) begin
    if (!Reset && imem_we) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_word timeout: in_ready=%b required 1", in_ready);
        break;
      end
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; restart = 1'b0;
    tick(2);
    n_checks++;
    if ({in_ready, cpu_rst_n, imem_we, err, err_code, word_count, imem_addr, imem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b rst_n=%b we=%b err=%b code=%b cnt=%0d required all 0",
               in_ready, cpu_rst_n, imem_we, err, err_code, word_count);
    end
    Reset = 1'b0;
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_basic_load;
    logic [31:0] exp [3];
    int bad;
    exp[0] = 32'h20080005; exp[1] = 32'h20090007; exp[2] = 32'h01095020;
    test_reset();
    send_word(exp[0], 1'b0);
    send_word(exp[1], 1'b0);
    send_word(exp[2], 1'b1);
    restart = 1'b1;  // ignored outside RUN
    n_checks++;
    if (word_count !== 7'd3 || in_ready !== 1'b0 || cpu_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_hold_entry: cnt=%0d rdy=%b rst_n=%b required 3 0 0", word_count, in_ready, cpu_rst_n);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_checks++;
      if (cpu_rst_n !== (i == 3)) begin
        n_fail++;
        $display("FAIL t1_hold_cycle%0d: rst_n=%b required %b", i, cpu_rst_n, (i == 3));
      end
    end
    restart = 1'b0;
    bad = 0;
    for (int i = 0; i < wq_addr.size() && i < 3; i++)
      if (wq_addr[i] !== 6'(i) || wq_data[i] !== exp[i]) bad++;
    n_checks++;
    if (wq_addr.size() != 3 || bad != 0) begin
      n_fail++;
      $display("FAIL t1_writes: count=%0d bad=%0d required 3 0", wq_addr.size(), bad);
    end
  endtask

  task automatic test_restart;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    wq_addr.delete(); wq_data.delete();
    n_checks++;
    if (cpu_rst_n !== 1'b0 || word_count !== 7'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_restart: rst_n=%b cnt=%0d rdy=%b required 0 0 1", cpu_rst_n, word_count, in_ready);
    end
    send_word(32'hDEADBEEF, 1'b1);
    tick(3);
    n_checks++;
    if (cpu_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_hold_end: rst_n=%b required 0", cpu_rst_n);
    end
    tick(1);
    n_checks++;
    if (cpu_rst_n !== 1'b1 || word_count !== 7'd1) begin
      n_fail++;
      $display("FAIL t4_run: rst_n=%b cnt=%0d required 1 1", cpu_rst_n, word_count);
    end
    n_checks++;
    if (wq_addr.size() != 1 || wq_addr[0] !== 6'd0 || wq_data[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL t4_write: count=%0d required 1 write of deadbeef at 0", wq_addr.size());
    end
  endtask

  task automatic test_valid_toggle;
    int bad;
    test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1);
      send_word(32'h100 + 32'(i), i == 4);
    end
    in_valid = 1'b1;
    in_data  = 32'hBAD0BAD0;
    tick(8);
    n_checks++;
    if (cpu_rst_n !== 1'b1 || in_ready !== 1'b0 || word_count !== 7'd5) begin
      n_fail++;
      $display("FAIL t2_run: rst_n=%b rdy=%b cnt=%0d required 1 0 5", cpu_rst_n, in_ready, word_count);
    end
    in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < wq_addr.size() && i < 5; i++)
      if (wq_addr[i] !== 6'(i) || wq_data[i] !== 32'h100 + 32'(i)) bad++;
    n_checks++;
    if (wq_addr.size() != 5 || bad != 0) begin
      n_fail++;
      $display("FAIL t2_writes: count=%0d bad=%0d required 5 0", wq_addr.size(), bad);
    end
  endtask

  task automatic test_overflow;
    int bad;
    test_reset();
    for (int i = 0; i < 64; i++) send_word(32'(i * 3 + 1), 1'b0);
    n_checks++;
    if (word_count !== 7'd64 || err !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_full: cnt=%0d err=%b rdy=%b required 64 0 1", word_count, err, in_ready);
    end
    send_word(32'hFFFF0065, 1'b0);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b01 || in_ready !== 1'b0 || cpu_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_err: err=%b code=%b rdy=%b rst_n=%b required 1 01 0 0", err, err_code, in_ready, cpu_rst_n);
    end
    restart = 1'b1;
    tick(6);
    restart = 1'b0;
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b01 || cpu_rst_n !== 1'b0 || word_count !== 7'd64 || imem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_absorb: err=%b code=%b rst_n=%b cnt=%0d we=%b required 1 01 0 64 0",
               err, err_code, cpu_rst_n, word_count, imem_we);
    end
    bad = 0;
    for (int i = 0; i < wq_addr.size() && i < 64; i++)
      if (wq_addr[i] !== 6'(i) || wq_data[i] !== 32'(i * 3 + 1)) bad++;
    n_checks++;
    if (wq_addr.size() != 64 || bad != 0) begin
      n_fail++;
      $display("FAIL t3_writes: count=%0d bad=%0d required 64 0", wq_addr.size(), bad);
    end
  endtask

  task automatic test_async_reset;
    test_reset();
    for (int i = 0; i < 10; i++) send_word(32'hA000 + 32'(i), 1'b0);
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, cpu_rst_n, imem_we, err, err_code, word_count, imem_addr, imem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL t5_async: rdy=%b we=%b cnt=%0d addr=%0d required all 0", in_ready, imem_we, word_count, imem_addr);
    end
    tick(1);
    Reset = 1'b0;
    n_checks++;
    if (wq_addr.size() != 9) begin
      n_fail++;
      $display("FAIL t5_partial: writes=%0d required 9", wq_addr.size());
    end
    wq_addr.delete(); wq_data.delete();
    send_word(32'hB0, 1'b0);
    send_word(32'hB1, 1'b1);
    tick(5);
    n_checks++;
    if (wq_addr.size() != 2 || wq_addr[0] !== 6'd0 || wq_addr[1] !== 6'd1 ||
        wq_data[1] !== 32'hB1 || cpu_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_reload: writes=%0d rst_n=%b required 2 at 0,1 and 1", wq_addr.size(), cpu_rst_n);
    end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum;
    test_reset();
    send_word(32'd1, 1'b0); send_word(32'd2, 1'b0); send_word(32'd3, 1'b0);
    send_word(32'd6, 1'b1);
    tick(4);
    n_checks++;
    if (cpu_rst_n !== 1'b1 || err !== 1'b0 || word_count !== 7'd3 || wq_addr.size() != 3) begin
      n_fail++;
      $display("FAIL t6_match: rst_n=%b err=%b cnt=%0d writes=%0d required 1 0 3 3",
               cpu_rst_n, err, word_count, wq_addr.size());
    end
    test_reset();
    send_word(32'd1, 1'b0); send_word(32'd2, 1'b0); send_word(32'd3, 1'b0);
    send_word(32'd7, 1'b1);
    tick(4);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b10 || cpu_rst_n !== 1'b0 || wq_addr.size() != 3) begin
      n_fail++;
      $display("FAIL t6_mismatch: err=%b code=%b rst_n=%b writes=%0d required 1 10 0 3",
               err, err_code, cpu_rst_n, wq_addr.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_restart();
    test_valid_toggle();
    test_overflow();
    test_async_reset();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
